// File: rtl/fp_normalizer_rounder_if.sv
// Handshake bundle between the mantissa adder, the normaliser/rounder and the result register.
// Signal names follow the adder datapath this block sits behind.

interface fp_normalizer_rounder_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);

  // Valid/ready: a transfer happens on a rising clock edge where valid and ready are both 1.
  // A source holds valid and its payload steady until that edge; ready may change freely.
  logic                     in_valid;
  logic                     in_ready;
  logic [MAN_W+3:0]         Suma_resul;
  logic                     Signo_sum;
  logic [EXP_W-1:0]         Exponente;

  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W+MAN_W:0]     Resultado;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output in_valid, Suma_resul, Signo_sum, Exponente, out_ready,
    input  in_ready, out_valid, Resultado, overflow, underflow
  );

  modport slave (
    input  in_valid, Suma_resul, Signo_sum, Exponente, out_ready,
    output in_ready, out_valid, Resultado, overflow, underflow
  );

endinterface

// File: rtl/fp_normalizer_rounder.sv
// Normalises the raw adder sum one bit per cycle, rounds to nearest-even and packs an
// IEEE-754 word. One operation in flight; state is visible on dbg_state.

module fp_normalizer_rounder #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fp_normalizer_rounder_if.slave    bus,
  output logic [1:0]                dbg_state
);

  localparam int SIG_W = MAN_W + 4;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [SIG_W-1:0]   sig_q;
  logic [EXP_W:0]     exp_q;
  logic               sign_q;

  logic [EXP_W:0]     exp_inc;
  logic               round_up;
  logic [MAN_W:0]     frac_sum;
  logic               round_carry;
  logic [EXP_W:0]     exp_rnd;
  logic               round_ovf;

  assign dbg_state = state;

  // The hidden bit is 1 in ROUND, so a carry out of the fraction means the significand became 2.0;
  // the fraction bits are then already zero, which is exactly the renormalised 1.0.
  always_comb begin
    exp_inc     = exp_q + 1'b1;
    round_up    = sig_q[1] & (sig_q[0] | sig_q[2]);
    frac_sum    = {1'b0, sig_q[MAN_W+1:2]} + {{MAN_W{1'b0}}, round_up};
    round_carry = frac_sum[MAN_W];
    exp_rnd     = exp_q + {{EXP_W{1'b0}}, round_carry};
    round_ovf   = (exp_rnd >= EXP_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      sig_q         <= '0;
      exp_q         <= '0;
      sign_q        <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.Resultado <= '0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            sig_q         <= bus.Suma_resul;
            exp_q         <= {1'b0, bus.Exponente};
            sign_q        <= bus.Signo_sum;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
            bus.in_ready  <= 1'b0;
            state         <= S_NORM;
          end
        end

        S_NORM: begin
          if (sig_q == '0) begin
            bus.Resultado <= '0;
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end else if (exp_q == '0 || exp_q == EXP_MAX) begin
            // Only a loaded exponent can be 0 or all-ones; later steps never produce them here.
            bus.Resultado <= {sign_q, {(EXP_W+MAN_W){1'b0}}};
            bus.underflow <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end else if (sig_q[SIG_W-1]) begin
            sig_q <= {1'b0, sig_q[SIG_W-1:2], sig_q[1] | sig_q[0]};
            exp_q <= exp_inc;
            if (exp_inc == EXP_MAX) begin
              bus.Resultado <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              bus.overflow  <= 1'b1;
              bus.out_valid <= 1'b1;
              state         <= S_DONE;
            end
          end else if (sig_q[SIG_W-2]) begin
            state <= S_ROUND;
          end else if (exp_q == EXP_ONE) begin
            bus.Resultado <= {sign_q, {(EXP_W+MAN_W){1'b0}}};
            bus.underflow <= 1'b1;
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end else begin
            sig_q <= {sig_q[SIG_W-2:0], 1'b0};
            exp_q <= exp_q - 1'b1;
          end
        end

        S_ROUND: begin
          if (round_ovf) begin
            bus.Resultado <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            bus.overflow  <= 1'b1;
          end else begin
            bus.Resultado <= {sign_q, exp_rnd[EXP_W-1:0], frac_sum[MAN_W-1:0]};
          end
          bus.out_valid <= 1'b1;
          state         <= S_DONE;
        end

        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer_rounder.sv
// Bench for fp_normalizer_rounder: directed vector table, randomized ops against an
// arithmetic reference model, output-hold and mid-operation reset sequences.

module tb_fp_normalizer_rounder;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int LAT_LIMIT = 100;

  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  fp_normalizer_rounder_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_normalizer_rounder #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [33:0] exp_q[$];
  int          lat_q[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  // Reference: locate the leading one, count the shifts the rules imply, round the
  // normalised significand arithmetically and pack.
  function automatic void ref_model(input logic [26:0] s, input logic sg, input logic [7:0] e,
                                    output logic [31:0] r, output logic o, output logic u,
                                    output int lat);
    int p;
    int k;
    int ex;
    logic [26:0] n;
    logic [24:0] keep;
    r = 32'h0; o = 1'b0; u = 1'b0; lat = 2;
    if (s == 27'h0) return;
    if (e == 8'd0 || e == 8'd255) begin
      r = {sg, 31'h0}; u = 1'b1; return;
    end
    p = 26;
    while (!s[p]) p--;
    ex = int'(e);
    if (p == 26) begin
      n = s >> 1;
      n[0] = s[1] | s[0];
      ex = ex + 1;
      if (ex >= 255) begin
        r = {sg, 8'hFF, 23'h0}; o = 1'b1; return;
      end
      lat = 4;
    end else begin
      k = 25 - p;
      if (k > ex - 1) begin
        r = {sg, 31'h0}; u = 1'b1; lat = 1 + ex; return;
      end
      n = s << k;
      ex = ex - k;
      lat = 3 + k;
    end
    keep = n[26:2];
    if (n[1] && (n[0] || n[2])) keep = keep + 25'd1;
    if (keep[24]) begin
      keep = keep >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) begin
      r = {sg, 8'hFF, 23'h0}; o = 1'b1; return;
    end
    r = {sg, ex[7:0], keep[22:0]};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle and out_ready high.
  task automatic do_op(input logic [26:0] s, input logic sg, input logic [7:0] e,
                       output logic [31:0] r, output logic o, output logic u, output int lat);
    check("in_ready_before_op", {63'h0, bus.in_ready}, 64'h1);
    bus.Suma_resul = s;
    bus.Signo_sum  = sg;
    bus.Exponente  = e;
    bus.in_valid   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    r = bus.Resultado;
    o = bus.overflow;
    u = bus.underflow;
    @(negedge clk);
  endtask

  typedef struct {
    logic [26:0] suma;
    logic        sign;
    logic [7:0]  expo;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [31:0] r;
    logic o;
    logic u;
    int lat;
    logic [33:0] exp_word;
    int exp_lat;
    logic [26:0] s;
    logic sg;
    logic [7:0] e;
    int p;
    bit seen;

    vecs[0]  = '{27'h4000000, 1'b0, 8'd127, 32'h40000000, 1'b0, 1'b0, 4};
    vecs[1]  = '{27'h3000000, 1'b0, 8'd127, 32'h3FC00000, 1'b0, 1'b0, 3};
    vecs[2]  = '{27'h2000002, 1'b0, 8'd127, 32'h3F800000, 1'b0, 1'b0, 3};
    vecs[3]  = '{27'h3FFFFFE, 1'b0, 8'd127, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[4]  = '{27'h0000004, 1'b0, 8'd127, 32'h34000000, 1'b0, 1'b0, 26};
    vecs[5]  = '{27'h0000004, 1'b0, 8'd5,   32'h00000000, 1'b0, 1'b1, 6};
    vecs[6]  = '{27'h4000000, 1'b1, 8'd254, 32'hFF800000, 1'b1, 1'b0, 2};
    vecs[7]  = '{27'h0000000, 1'b1, 8'd127, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[8]  = '{27'h3000000, 1'b1, 8'd0,   32'h80000000, 1'b0, 1'b1, 2};
    vecs[9]  = '{27'h2000000, 1'b0, 8'd255, 32'h00000000, 1'b0, 1'b1, 2};
    vecs[10] = '{27'h2000006, 1'b0, 8'd127, 32'h3F800002, 1'b0, 1'b0, 3};
    vecs[11] = '{27'h2000003, 1'b0, 8'd127, 32'h3F800001, 1'b0, 1'b0, 3};
    vecs[12] = '{27'h4000006, 1'b0, 8'd127, 32'h40000001, 1'b0, 1'b0, 4};
    vecs[13] = '{27'h3FFFFFE, 1'b1, 8'd254, 32'hFF800000, 1'b1, 1'b0, 3};
    vecs[14] = '{27'h0000004, 1'b0, 8'd24,  32'h00800000, 1'b0, 1'b0, 26};
    vecs[15] = '{27'h0000004, 1'b0, 8'd23,  32'h00000000, 1'b0, 1'b1, 24};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.Suma_resul = '0;
    bus.Signo_sum  = 1'b0;
    bus.Exponente  = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_in_ready",  {63'h0, bus.in_ready}, 64'h1);
    check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_resultado", {32'h0, bus.Resultado}, 64'h0);
    check("rst_overflow",  {63'h0, bus.overflow}, 64'h0);
    check("rst_underflow", {63'h0, bus.underflow}, 64'h0);
    check("rst_state",     {62'h0, dbg_state}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].suma, vecs[i].sign, vecs[i].expo, r, o, u, lat);
      check($sformatf("vec%0d_res", i), {32'h0, r}, {32'h0, vecs[i].res});
      check($sformatf("vec%0d_ovf", i), {63'h0, o}, {63'h0, vecs[i].ovf});
      check($sformatf("vec%0d_unf", i), {63'h0, u}, {63'h0, vecs[i].unf});
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      p = $urandom_range(0, 27);
      s = 27'($urandom);
      if (p == 27) s = 27'h0;
      else begin
        s = s & ((27'd1 << (p + 1)) - 27'd1);
        if ($urandom_range(0, 3) == 0) s[1:0] = 2'b10;
        s[p] = 1'b1;
      end
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: e = 8'($urandom_range(1, 30));
        1: e = 8'($urandom_range(240, 255));
        2: e = 8'($urandom_range(0, 255));
        default: e = 8'd127;
      endcase
      ref_model(s, sg, e, r, o, u, lat);
      exp_q.push_back({o, u, r});
      lat_q.push_back(lat);
      do_op(s, sg, e, r, o, u, lat);
      exp_word = exp_q.pop_front();
      exp_lat  = lat_q.pop_front();
      check($sformatf("rnd%0d_s%07h_e%0d_out", i, s, e), {30'h0, o, u, r}, {30'h0, exp_word});
      check($sformatf("rnd%0d_s%07h_e%0d_lat", i, s, e), 64'(lat), 64'(exp_lat));
    end

    // Output held while downstream stalls; a new request must be ignored
    bus.out_ready  = 1'b0;
    bus.Suma_resul = 27'h3000000;
    bus.Signo_sum  = 1'b0;
    bus.Exponente  = 8'd127;
    bus.in_valid   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
    end
    check("hold_lat", 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d_res", i), {32'h0, bus.Resultado}, 64'h3FC00000);
      check($sformatf("hold%0d_valid", i), {63'h0, bus.out_valid}, 64'h1);
      check($sformatf("hold%0d_in_ready", i), {63'h0, bus.in_ready}, 64'h0);
      bus.Suma_resul = 27'h4000000;
      bus.in_valid   = 1'b1;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", {63'h0, bus.out_valid}, 64'h0);
    check("hold_release_in_ready", {63'h0, bus.in_ready}, 64'h1);

    // Reset in the middle of a long normalisation
    bus.Suma_resul = 27'h0000004;
    bus.Signo_sum  = 1'b1;
    bus.Exponente  = 8'd127;
    bus.in_valid   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_in_norm", {62'h0, dbg_state}, 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_state", {62'h0, dbg_state}, 64'h0);
    check("midrst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("midrst_in_ready", {63'h0, bus.in_ready}, 64'h1);
    check("midrst_resultado", {32'h0, bus.Resultado}, 64'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("midrst_no_result", {63'h0, seen}, 64'h0);

    do_op(27'h4000000, 1'b0, 8'd127, r, o, u, lat);
    check("post_rst_res", {32'h0, r}, 64'h40000000);
    check("post_rst_lat", 64'(lat), 64'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
